// File: rtl/imm_pkg.sv
// imm_pkg: shared immediate-format codes, widths and payload types
package imm_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN_DEFAULT = 32;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_J = 3'd3,
    IMM_U = 3'd4,
    IMM_Z = 3'd5
  } imm_src_e;
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] imm;
    logic [XLEN_DEFAULT-1:0] target;
    logic                    illegal;
  } imm_payload_t;
  function automatic logic is_reserved(input logic [2:0] src);
    return src > 3'(IMM_Z);
  endfunction
endpackage

// File: rtl/imm_format.sv
// imm_format: combinational immediate decode and extension to XLEN
module imm_format
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int ILEN = ILEN_DEFAULT
) (
  input  logic [ILEN-1:0] instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [31:0] imm32;
  logic        unused_opcode;
  assign unused_opcode = ^instr[6:0];
  // Build the 32-bit immediate; every format, including U, is then sign-extended from bit 31
  always_comb begin
    imm32 = imm_src == 3'(IMM_I) ? {{20{instr[31]}}, instr[31:20]} :
            imm_src == 3'(IMM_S) ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
            imm_src == 3'(IMM_B) ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
            imm_src == 3'(IMM_J) ? {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0} :
            imm_src == 3'(IMM_U) ? {instr[31:12], 12'b0} :
            imm_src == 3'(IMM_Z) ? {27'b0, instr[19:15]} :
            32'b0;
    illegal = is_reserved(imm_src);
  end
  assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: pipelined immediate generator with pc-relative target behind a 2-entry skid buffer
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int ILEN = ILEN_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] target,
  output logic            illegal
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_e;
  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic            illegal;
  } payload_t;
  state_e   state, state_n;
  payload_t main_q, skid_q, p_in;
  logic     in_xfer, out_xfer, load_main, load_skid, skid_to_main;
  logic [XLEN-1:0] fmt_imm;
  logic            fmt_illegal;
  imm_format #(.XLEN(XLEN), .ILEN(ILEN)) u_fmt (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (fmt_imm),
    .illegal (fmt_illegal)
  );
  assign p_in      = '{imm: fmt_imm, target: pc + fmt_imm, illegal: fmt_illegal};
  assign out_valid = state != EMPTY;
  assign in_ready  = state != TWO;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign imm_ext   = main_q.imm;
  assign target    = main_q.target;
  assign illegal   = main_q.illegal;
  // Occupancy next-state and which register captures the incoming payload
  always_comb begin
    state_n      = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    case (state)
      EMPTY: begin
        load_main = in_xfer;
        state_n   = in_xfer ? ONE : EMPTY;
      end
      ONE: begin
        load_main = in_xfer && out_xfer;
        load_skid = in_xfer && !out_xfer;
        state_n   = load_skid ? TWO : (out_xfer && !in_xfer) ? EMPTY : ONE;
      end
      TWO: begin
        skid_to_main = out_xfer;
        state_n      = out_xfer ? ONE : TWO;
      end
      default: state_n = EMPTY;
    endcase
  end
  // State and payload registers; reset flushes both entries and clears payloads
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state  <= state_n;
      main_q <= load_main ? p_in : skid_to_main ? skid_q : main_q;
      skid_q <= load_skid ? p_in : skid_q;
    end
  end
endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage: directed self-checking bench for imm_gen_stage at XLEN 32 and 64
module tb_imm_gen_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        v32, r32, ov32, or32, ill32;
  logic [31:0] instr32, pc32, imm32, tgt32;
  logic [2:0]  src32;
  logic        v64, r64, ov64, or64, ill64;
  logic [31:0] instr64;
  logic [63:0] pc64, imm64, tgt64;
  logic [2:0]  src64;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32)) u32 (
    .clk(clk), .reset(reset), .in_valid(v32), .in_ready(r32), .instr(instr32), .pc(pc32),
    .imm_src(src32), .out_valid(ov32), .out_ready(or32), .imm_ext(imm32), .target(tgt32),
    .illegal(ill32)
  );
  imm_gen_stage #(.XLEN(64)) u64 (
    .clk(clk), .reset(reset), .in_valid(v64), .in_ready(r64), .instr(instr64), .pc(pc64),
    .imm_src(src64), .out_valid(ov64), .out_ready(or64), .imm_ext(imm64), .target(tgt64),
    .illegal(ill64)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic put32(input logic v, input logic [31:0] i, input logic [2:0] s, input logic [31:0] p);
    v32 = v; instr32 = i; src32 = s; pc32 = p;
  endtask

  initial begin
    reset = 1'b1;
    put32(1'b1, 32'h00500093, 3'd0, 32'h0);
    or32 = 1'b1;
    v64 = 1'b1; instr64 = 32'h00500093; src64 = 3'd0; pc64 = 64'h0; or64 = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_in_ready", 64'(r32), 64'd1);
    check("rst_imm", 64'(imm32), 64'd0);
    check("rst_target", 64'(tgt32), 64'd0);
    check("rst_illegal", 64'(ill32), 64'd0);
    check("rst64_out_valid", 64'(ov64), 64'd0);
    reset = 1'b0;
    v64 = 1'b0;
    put32(1'b1, 32'hFFF00093, 3'd0, 32'h100);
    tick();
    check("i_valid", 64'(ov32), 64'd1);
    check("i_imm", 64'(imm32), 64'hFFFFFFFF);
    check("i_target", 64'(tgt32), 64'h000000FF);
    check("i_illegal", 64'(ill32), 64'd0);
    put32(1'b1, 32'hFE000EE3, 3'd2, 32'h200);
    tick();
    check("b_imm", 64'(imm32), 64'hFFFFFFFC);
    check("b_target", 64'(tgt32), 64'h000001FC);
    put32(1'b1, 32'hFE112E23, 3'd1, 32'h300);
    tick();
    check("s_imm", 64'(imm32), 64'hFFFFFFFC);
    check("s_target", 64'(tgt32), 64'h000002FC);
    put32(1'b1, 32'h0080006F, 3'd3, 32'h400);
    tick();
    check("j_imm", 64'(imm32), 64'h8);
    check("j_target", 64'(tgt32), 64'h408);
    put32(1'b1, 32'hFFFFFFFF, 3'd7, 32'h40);
    tick();
    check("r7_imm", 64'(imm32), 64'd0);
    check("r7_illegal", 64'(ill32), 64'd1);
    check("r7_target", 64'(tgt32), 64'h40);
    put32(1'b1, 32'hFFFFFFFF, 3'd6, 32'h40);
    tick();
    check("r6_imm", 64'(imm32), 64'd0);
    check("r6_illegal", 64'(ill32), 64'd1);
    check("r6_target", 64'(tgt32), 64'h40);
    put32(1'b1, 32'h000F8000, 3'd5, 32'h40);
    tick();
    check("z_imm", 64'(imm32), 64'h1F);
    check("z_illegal", 64'(ill32), 64'd0);
    check("z_target", 64'(tgt32), 64'h5F);
    put32(1'b0, 32'h0, 3'd0, 32'h0);
    tick();
    check("drain_valid", 64'(ov32), 64'd0);
    v64 = 1'b1; instr64 = 32'h123450B7; src64 = 3'd4; pc64 = 64'h1000;
    tick();
    check("u64a_valid", 64'(ov64), 64'd1);
    check("u64a_imm", imm64, 64'h0000000012345000);
    check("u64a_target", tgt64, 64'h0000000012346000);
    instr64 = 32'h80000037;
    tick();
    check("u64b_imm", imm64, 64'hFFFFFFFF80000000);
    check("u64b_target", tgt64, 64'hFFFFFFFF80001000);
    instr64 = 32'hFFF00093; src64 = 3'd0;
    tick();
    check("i64_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    check("i64_target", tgt64, 64'h0000000000000FFF);
    v64 = 1'b0;
    or32 = 1'b0;
    put32(1'b1, 32'h00100093, 3'd0, 32'h0);
    check("bp_ready0", 64'(r32), 64'd1);
    tick();
    check("bp_valid1", 64'(ov32), 64'd1);
    check("bp_ready1", 64'(r32), 64'd1);
    put32(1'b1, 32'h00200093, 3'd0, 32'h0);
    tick();
    check("bp_ready2", 64'(r32), 64'd0);
    check("bp_hold1", 64'(imm32), 64'd1);
    put32(1'b1, 32'h00300093, 3'd0, 32'h0);
    tick();
    check("bp_ready3", 64'(r32), 64'd0);
    check("bp_stable", 64'(imm32), 64'd1);
    check("bp_valid3", 64'(ov32), 64'd1);
    or32 = 1'b1;
    tick();
    check("bp_out2", 64'(imm32), 64'd2);
    check("bp_ready4", 64'(r32), 64'd1);
    tick();
    check("bp_out3", 64'(imm32), 64'd3);
    check("bp_valid5", 64'(ov32), 64'd1);
    put32(1'b0, 32'h0, 3'd0, 32'h0);
    tick();
    check("bp_empty", 64'(ov32), 64'd0);
    or32 = 1'b0;
    put32(1'b1, 32'h00100093, 3'd0, 32'h0);
    tick();
    put32(1'b1, 32'h00200093, 3'd0, 32'h0);
    tick();
    check("fill_two", 64'(r32), 64'd0);
    reset = 1'b1;
    put32(1'b1, 32'h00700093, 3'd0, 32'h0);
    tick();
    check("flush_valid", 64'(ov32), 64'd0);
    check("flush_ready", 64'(r32), 64'd1);
    check("flush_imm", 64'(imm32), 64'd0);
    reset = 1'b0;
    or32 = 1'b1;
    put32(1'b1, 32'h00900093, 3'd0, 32'h0);
    tick();
    check("post_valid", 64'(ov32), 64'd1);
    check("post_imm", 64'(imm32), 64'd9);
    check("post_target", 64'(tgt32), 64'd9);
    put32(1'b0, 32'h0, 3'd0, 32'h0);
    tick();
    check("post_no_stale", 64'(ov32), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
